// File: rtl/quad_enc_counter.sv
// Quadrature encoder front end: synchronizer, per-channel glitch filter, x4 decoder
// with illegal-transition detection, and a signed wrapping position counter.
module quad_enc_counter #(
    parameter int unsigned FILTER_LEN = 4,
    parameter bit          INVERT_DIR = 1'b0,
    parameter int unsigned COUNT_W    = 32
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clear_count,
    output logic [COUNT_W-1:0] count_export,
    output logic               step_pulse,
    output logic               dir,
    output logic               err_sticky
);

    localparam logic [7:0]         FILT_LAST   = 8'(FILTER_LEN - 1);
    localparam logic [8:0]         SETTLE_DONE = 9'(FILTER_LEN + 3);
    localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);

    // Bit 1 carries channel A, bit 0 channel B, so filt_q is the decoder state {A,B}.
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       filt_q, filt_d;
    logic [1:0][7:0]  fcnt_q, fcnt_d;
    logic [1:0]       prev_q;
    logic [8:0]       settle_q;
    logic [COUNT_W-1:0] count_q, count_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic fwd, rev, bad, up, settled;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = fcnt_q[i] + 8'd1;
            if (s2_q[i] == filt_q[i]) begin
                fcnt_d[i] = 8'd0;
            end else if (fcnt_q[i] == FILT_LAST) begin
                filt_d[i] = s2_q[i];
                fcnt_d[i] = 8'd0;
            end
        end
    end

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        case ({prev_q, filt_q})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: bad = 1'b1;
            default: ;
        endcase
    end

    assign up      = fwd ? ~INVERT_DIR : INVERT_DIR;
    assign settled = (settle_q == SETTLE_DONE);

    // Clear outranks any step or error decoded in the same cycle.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        err_d   = err_q;
        step_d  = 1'b0;
        if (clear_count) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (settled) begin
            if (bad) begin
                err_d = 1'b1;
            end else if (fwd || rev) begin
                step_d  = 1'b1;
                dir_d   = up;
                count_d = up ? (count_q + ONE) : (count_q - ONE);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            filt_q   <= '0;
            fcnt_q   <= '0;
            prev_q   <= '0;
            settle_q <= '0;
            count_q  <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= {enc_a, enc_b};
            s2_q     <= s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            prev_q   <= filt_q;
            settle_q <= settled ? settle_q : (settle_q + 9'd1);
            count_q  <= count_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign count_export = count_q;
    assign step_pulse   = step_q;
    assign dir          = dir_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_quad_enc_counter.sv
// Directed bench for quad_enc_counter: a normal and a direction-inverted instance share
// the pins; a cycle-level reference model is compared on every falling edge.
module tb_quad_enc_counter;

    localparam int FL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, a = 1'b1, b = 1'b1, clr = 1'b0;
    logic [31:0] cnt0, cnt1;
    logic stp0, stp1, dir0, dir1, err0, err1;

    quad_enc_counter #(.FILTER_LEN(FL), .INVERT_DIR(1'b0), .COUNT_W(32)) dut0 (
        .clk_clk(clk), .reset_reset(rst), .enc_a(a), .enc_b(b), .clear_count(clr),
        .count_export(cnt0), .step_pulse(stp0), .dir(dir0), .err_sticky(err0));

    quad_enc_counter #(.FILTER_LEN(FL), .INVERT_DIR(1'b1), .COUNT_W(32)) dut1 (
        .clk_clk(clk), .reset_reset(rst), .enc_a(a), .enc_b(b), .clear_count(clr),
        .count_export(cnt1), .step_pulse(stp1), .dir(dir1), .err_sticky(err1));

    int n_vec = 0, n_bad = 0, n_steps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: position on the Gray cycle 00,10,11,01 gives the step as a
    // difference mod 4; a level is accepted once the last FL synchronized samples
    // all disagree with the accepted level.
    logic [1:0]    m_s1 = 0, m_s2 = 0, m_filt = 0, m_prev = 0;
    logic [FL-1:0] m_hist_a = 0, m_hist_b = 0;
    logic [31:0]   m_cnt0 = 0, m_cnt1 = 0;
    logic          m_dir0 = 0, m_dir1 = 0, m_err = 0, m_step = 0;
    int            m_since = 0;

    function automatic int pos(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int d;
        logic up;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_prev = 0;
            m_hist_a = 0; m_hist_b = 0;
            m_cnt0 = 0; m_cnt1 = 0; m_dir0 = 0; m_dir1 = 0;
            m_err = 0; m_step = 0; m_since = 0;
        end else begin
            m_step = 0;
            if (clr) begin
                m_cnt0 = 0; m_cnt1 = 0; m_err = 0;
            end else if (m_since >= FL + 3 && m_filt != m_prev) begin
                d = (pos(m_filt) - pos(m_prev)) & 3;
                if (d == 2) begin
                    m_err = 1;
                end else begin
                    up = (d == 1);
                    m_step = 1;
                    m_cnt0 = up ? m_cnt0 + 32'd1 : m_cnt0 - 32'd1;
                    m_cnt1 = up ? m_cnt1 - 32'd1 : m_cnt1 + 32'd1;
                    m_dir0 = up;
                    m_dir1 = !up;
                end
            end
            m_prev = m_filt;
            m_hist_a = {m_hist_a[FL-2:0], m_s2[1]};
            m_hist_b = {m_hist_b[FL-2:0], m_s2[0]};
            if (m_hist_a == {FL{~m_filt[1]}}) m_filt[1] = ~m_filt[1];
            if (m_hist_b == {FL{~m_filt[0]}}) m_filt[0] = ~m_filt[0];
            m_s2 = m_s1;
            m_s1 = {a, b};
            if (m_since < 1000) m_since++;
        end
    end

    always @(negedge clk) begin
        chk("count0", cnt0, m_cnt0);
        chk("count1", cnt1, m_cnt1);
        chk("step0", {31'd0, stp0}, {31'd0, m_step});
        chk("step1", {31'd0, stp1}, {31'd0, m_step});
        chk("dir0", {31'd0, dir0}, {31'd0, m_dir0});
        chk("dir1", {31'd0, dir1}, {31'd0, m_dir1});
        chk("err0", {31'd0, err0}, {31'd0, m_err});
        chk("err1", {31'd0, err1}, {31'd0, m_err});
        if (stp0 === 1'b1) n_steps++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pins(input logic [1:0] v, input int hold);
        {a, b} = v;
        tick(hold);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(2);
    endtask

    logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] rev_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int base, lat;

    initial begin
        // Power-up with both pins high: settle window must swallow the 00->11 jump.
        tick(5);
        rst = 1'b0;
        tick(20);
        chk("t1_count", cnt0, 32'd0);
        chk("t1_err", {31'd0, err0}, 32'd0);
        chk("t1_steps", n_steps, 32'd0);

        pins(2'b01, 10);
        pins(2'b00, 10);
        chk("t1_walk_home", cnt0, 32'd2);
        pulse_clear();
        chk("t1_cleared", cnt0, 32'd0);

        // Forward x3 with first-edge latency measurement.
        base = n_steps;
        {a, b} = 2'b10;
        lat = 0;
        while (lat < 40 && cnt0 == 32'd0) begin
            tick(1);
            lat++;
        end
        chk("t2_latency_edges", lat, 32'd7);
        tick(3);
        for (int i = 1; i < 12; i++) pins(fwd_seq[i % 4], 10);
        chk("t2_count0", cnt0, 32'd12);
        chk("t2_count1", cnt1, 32'hFFFF_FFF4);
        chk("t2_dir0", {31'd0, dir0}, 32'd1);
        chk("t2_steps", n_steps - base, 32'd12);
        pulse_clear();

        for (int i = 0; i < 4; i++) pins(rev_seq[i], 10);
        chk("t3_count0", cnt0, 32'hFFFF_FFFC);
        chk("t3_dir0", {31'd0, dir0}, 32'd0);
        chk("t3_count1", cnt1, 32'd4);
        chk("t3_dir1", {31'd0, dir1}, 32'd1);
        pulse_clear();

        // Glitches on A: 3 cycles rejected, 4 cycles accepted both ways.
        base = n_steps;
        pins(2'b10, 3);
        pins(2'b00, 10);
        chk("t4_short_count", cnt0, 32'd0);
        chk("t4_short_steps", n_steps - base, 32'd0);
        pins(2'b10, 4);
        pins(2'b00, 3);
        chk("t4_long_up", cnt0, 32'd1);
        tick(10);
        chk("t4_long_back", cnt0, 32'd0);
        chk("t4_long_steps", n_steps - base, 32'd2);
        chk("t4_dir", {31'd0, dir0}, 32'd0);

        for (int i = 0; i < 4; i++) pins(fwd_seq[i], 10);
        pins(2'b11, 10);
        chk("t5_err", {31'd0, err0}, 32'd1);
        chk("t5_count_held", cnt0, 32'd4);
        pulse_clear();
        chk("t5_err_cleared", {31'd0, err0}, 32'd0);
        chk("t5_count_cleared", cnt0, 32'd0);
        pins(2'b01, 10);
        pins(2'b00, 10);
        chk("t5_no_new_err", {31'd0, err0}, 32'd0);
        chk("t5_count", cnt0, 32'd2);
        pulse_clear();

        // Signed overflow wrap.
        force dut0.count_q = 32'h7FFF_FFFF;
        m_cnt0 = 32'h7FFF_FFFF;
        tick(1);
        release dut0.count_q;
        tick(1);
        chk("t6_preload", cnt0, 32'h7FFF_FFFF);
        pins(2'b10, 10);
        chk("t6_wrap", cnt0, 32'h8000_0000);

        // Clear on the very edge the 10->11 step is decoded.
        base = n_steps;
        pins(2'b11, 6);
        clr = 1'b1;
        tick(1);
        chk("t6_clr_count", cnt0, 32'd0);
        chk("t6_clr_step", {31'd0, stp0}, 32'd0);
        clr = 1'b0;
        tick(10);
        chk("t6_clr_after", cnt0, 32'd0);
        chk("t6_clr_steps", n_steps - base, 32'd0);

        // Reset mid-operation with pins high restarts settle cleanly.
        pins(2'b01, 10);
        chk("t7_pre_reset", cnt0, 32'd1);
        pins(2'b11, 2);
        rst = 1'b1;
        tick(2);
        chk("t7_reset_count", cnt0, 32'd0);
        chk("t7_reset_dir", {31'd0, dir0}, 32'd0);
        rst = 1'b0;
        tick(20);
        chk("t7_settle_count", cnt0, 32'd0);
        chk("t7_settle_err", {31'd0, err0}, 32'd0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_enc_counter.md
Name: quad_enc_counter

Overview:
- Decodes one incremental quadrature encoder (channels A/B) into a signed 32-bit position count.
- Sits directly upstream of the enc0 PIO in soc_system. count_export drives pio_mmap_enc0_external_connection_export[31:0], so the HPS can read the position over the lightweight bridge.
- Includes an input synchronizer, a per-channel glitch filter, an x4 decoder, an illegal-transition detector and a software clear.

Parameters:
FILTER_LEN, 4, cycles a synchronized level must stay stable before it is accepted; legal range 1..255
INVERT_DIR, 0, 1 swaps the count direction
COUNT_W, 32, count width; fixed at 32 to match the PIO width

Ports:
clk_clk  in  1  system clock; the single clock domain, shared with the PIO
reset_reset  in  1  synchronous, active-high reset
enc_a  in  1  encoder channel A; asynchronous pin
enc_b  in  1  encoder channel B; asynchronous pin
clear_count  in  1  synchronous, level-sensitive; clears the count and the error flag
count_export  out  32  signed position count, to the PIO export
step_pulse  out  1  one-cycle pulse on every accepted count change
dir  out  1  direction of the last accepted step: 1 = up, 0 = down
err_sticky  out  1  set on an illegal transition (A and B change together); sticky until clear

Behaviour:
- Clock and reset:
  - One clock, clk_clk.
  - reset_reset is synchronous and active-high.
- Reset values:
  - Outputs: count_export=0, step_pulse=0, dir=0, err_sticky=0.
  - Internal: synchronizer, filter and prev registers = 0; filter counters = 0; settle counter = 0.
- Synchronizer: two flops per channel (s1 then s2).
- Glitch filter, per channel, evaluated each cycle:
  - If s2 == filt: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: filt <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Effect: a pulse shorter than FILTER_LEN cycles never reaches filt.
- Decode:
  - st = {filt_a, filt_b}; prev <= st every cycle.
  - Up (+1) sequence: 00→10→11→01→00. The reverse order is down (−1).
  - If INVERT_DIR=1, up and down are swapped.
  - st == prev: no action.
  - Both bits differ: err_sticky <= 1; count unchanged; no step_pulse.
- Count update:
  - count_export, dir and step_pulse are all registered.
  - They update on the edge after filt changes.
  - Arithmetic is 32-bit two's-complement with wrap: 0x7FFFFFFF+1 → 0x80000000, 0x00000000−1 → 0xFFFFFFFF.
- Latency:
  - Edge 0 is the first clk_clk edge at which s1 samples the new pin level.
  - filt changes at edge 1+FILTER_LEN.
  - count_export changes at edge 2+FILTER_LEN.
- Settle after reset:
  - A settle counter runs for FILTER_LEN+3 cycles after reset deasserts.
  - While settling: decode is disabled (no count change, no step_pulse, no err_sticky); prev still tracks st.
  - This prevents a spurious step or error when the pins power up non-zero.
- clear_count:
  - count_export <= 0, err_sticky <= 0, step_pulse <= 0.
  - Wins over a step or error detected in the same cycle. That event is dropped, but prev still updates.
  - Held high, the count stays 0.
  - dir is unaffected.
- Priority: reset_reset > clear_count > decode.
- Reset mid-operation: all state returns to reset values on the next edge, and the settle period restarts.
- step_pulse: high for exactly one cycle per accepted transition. It can be high on consecutive cycles only if filt changes on consecutive cycles.

Test Plan:
1. Reset then hold A=B=1 from the first cycle, FILTER_LEN=4 → after settle: count_export=0, err_sticky=0, no step_pulse.
2. Forward sequence 00→10→11→01→00 repeated 3 times, each state held 10 cycles → count_export=12, dir=1, 12 step_pulses; the first count change lands 6 cycles after s1 samples the first edge.
3. Reverse sequence 4 steps from count 0 → count_export=0xFFFFFFFC, dir=0; repeat with INVERT_DIR=1 → count_export=4.
4. A glitch high for 3 cycles with FILTER_LEN=4 → no count change; a 4-cycle glitch → count +1, then −1 when the pin returns.
5. Jump 00→11 (both pins together, held 10 cycles) → err_sticky=1, count unchanged; then clear_count for 1 cycle → err_sticky=0, count_export=0.
6. Preload to 0x7FFFFFFF via 0x7FFFFFFF forward steps (or a force in the bench), one more forward step → 0x80000000. Also: clear_count asserted in the same cycle a step is decoded → count_export=0, no step_pulse.
